// File: rtl/isa_mon_pkg.sv
// Shared definitions for the ISA test-run monitor.
//   mon_state_e  : sequencer states
//   CSR_DONE_BIT : tohost bit that marks a completion write
//   CODE_W       : width of the exit code carried in tohost[31:1]
package isa_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } mon_state_e;

   localparam int CSR_DONE_BIT = 0;
   localparam int CODE_W       = 31;

endpackage

// File: rtl/isa_mon_hart_latch.sv
// Per-hart completion latch: records the first tohost write that has the
// done bit set and keeps its exit code until the next run is launched.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   clear_i       : wipe flag and code (run launch)
//   capture_en_i  : completions are accepted only while high (RUN)
//   wr_en_i       : tohost write strobe
//   wr_data_i     : tohost write data
//   done_o        : registered completion flag
//   done_nxt_o    : flag value being loaded this cycle
//   code_nxt_o    : code value being loaded this cycle
module isa_mon_hart_latch
   import isa_mon_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              capture_en_i,
   input  logic              wr_en_i,
   input  logic [31:0]       wr_data_i,
   output logic              done_o,
   output logic              done_nxt_o,
   output logic [CODE_W-1:0] code_nxt_o
);

   logic              done_q, done_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              complete;

   // Once the flag is set further writes are dropped: first completion wins.
   assign complete = capture_en_i & wr_en_i & wr_data_i[CSR_DONE_BIT] & ~done_q;

   always_comb begin
      done_d = done_q;
      code_d = code_q;
      if (clear_i) begin
         done_d = 1'b0;
         code_d = '0;
      end else if (complete) begin
         done_d = 1'b1;
         code_d = wr_data_i[CODE_W:1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
         code_q <= '0;
      end else begin
         done_q <= done_d;
         code_q <= code_d;
      end
   end

   assign done_o     = done_q;
   assign done_nxt_o = done_d;
   assign code_nxt_o = code_d;

endmodule

// File: rtl/isa_run_monitor.sv
// ISA test-run monitor: holds the CPU in reset for a fixed time after start,
// lets it run while watching per-hart tohost writes, and reports pass/fail,
// timeout and the first failing hart once every hart has finished.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   start                 : launch pulse (accepted in IDLE/DONE)
//   csr_wr_en/csr_wr_data : per-hart tohost writes, hart h at [32h+31:32h]
//   cpu_rst               : reset to the CPU(s)
//   busy/done             : run in progress / run finished
//   pass/timeout          : result, valid while done
//   fail_hart/fail_code   : lowest-index hart with nonzero exit code
//   cycle_count           : RUN-phase cycles, saturating
//   hart_done             : per-hart completion flags
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for start, CPU held in reset
// HOLD    | CPU reset held for RESET_HOLD_CYCLES cycles
// RUN     | CPU running, counting cycles, latching tohost
// DONE    | result frozen, CPU in reset, waiting for start
module isa_run_monitor
   import isa_mon_pkg::*;
#(
   parameter int NUM_HARTS         = 1,
   parameter int RESET_HOLD_CYCLES = 30,
   parameter int TIMEOUT_CYCLES    = 1000,
   parameter int CNT_W             = 32,
   localparam int FH_W             = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [NUM_HARTS-1:0]    csr_wr_en,
   input  logic [32*NUM_HARTS-1:0] csr_wr_data,
   output logic                    cpu_rst,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic                    timeout,
   output logic [FH_W-1:0]         fail_hart,
   output logic [CODE_W-1:0]       fail_code,
   output logic [CNT_W-1:0]        cycle_count,
   output logic [NUM_HARTS-1:0]    hart_done
);

   localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TO_LIMIT  = CNT_W'(TIMEOUT_CYCLES - 1);

   mon_state_e        state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d, cnt_next;
   logic              pass_q, pass_d, timeout_q, timeout_d;
   logic [FH_W-1:0]   fail_hart_q, fail_hart_d;
   logic [CODE_W-1:0] fail_code_q, fail_code_d;

   logic                 enter_hold, in_run, timeout_hit, any_fail;
   logic [NUM_HARTS-1:0] done_flags, done_nxt;
   logic [CODE_W-1:0]    code_nxt [NUM_HARTS];

   assign in_run = (state_q == ST_RUN);

   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
      isa_mon_hart_latch u_latch (
         .clk          (clk),
         .rst_n        (rst_n),
         .clear_i      (enter_hold),
         .capture_en_i (in_run),
         .wr_en_i      (csr_wr_en[h]),
         .wr_data_i    (csr_wr_data[32*h +: 32]),
         .done_o       (done_flags[h]),
         .done_nxt_o   (done_nxt[h]),
         .code_nxt_o   (code_nxt[h])
      );
   end

   // The count taken into the final RUN cycle is what gets frozen, so timeout
   // is judged on the incremented value: DONE is entered showing TIMEOUT-1.
   assign cnt_next    = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_next >= TO_LIMIT);

   // Priority is evaluated on the values being latched, so the registered
   // result already matches hart_done in the first DONE cycle.
   always_comb begin
      fail_hart_d = '0;
      fail_code_d = '0;
      any_fail    = 1'b0;
      for (int h = NUM_HARTS - 1; h >= 0; h--) begin
         if (done_nxt[h] && (code_nxt[h] != '0)) begin
            fail_hart_d = FH_W'(h);
            fail_code_d = code_nxt[h];
            any_fail    = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      enter_hold  = 1'b0;
      hold_cnt_d  = hold_cnt_q;
      cycle_cnt_d = cycle_cnt_q;
      pass_d      = pass_q;
      timeout_d   = timeout_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_HOLD;
               enter_hold  = 1'b1;
               hold_cnt_d  = HOLD_LOAD;
               cycle_cnt_d = '0;
               pass_d      = 1'b0;
               timeout_d   = 1'b0;
            end
         end
         ST_HOLD: begin
            if (hold_cnt_q == '0) state_d = ST_RUN;
            else                  hold_cnt_d = hold_cnt_q - HOLD_W'(1);
         end
         ST_RUN: begin
            cycle_cnt_d = cnt_next;
            // Completion is checked first so it beats a same-cycle timeout.
            if (&done_nxt) begin
               state_d = ST_DONE;
               pass_d  = ~any_fail;
            end else if (timeout_hit) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         hold_cnt_q  <= '0;
         cycle_cnt_q <= '0;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
         fail_hart_q <= '0;
         fail_code_q <= '0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         cycle_cnt_q <= cycle_cnt_d;
         pass_q      <= pass_d;
         timeout_q   <= timeout_d;
         fail_hart_q <= fail_hart_d;
         fail_code_q <= fail_code_d;
      end
   end

   assign cpu_rst     = (state_q != ST_RUN);
   assign busy        = (state_q == ST_HOLD) || (state_q == ST_RUN);
   assign done        = (state_q == ST_DONE);
   assign pass        = pass_q;
   assign timeout     = timeout_q;
   assign fail_hart   = fail_hart_q;
   assign fail_code   = fail_code_q;
   assign cycle_count = cycle_cnt_q;
   assign hart_done   = done_flags;

endmodule

// File: tb/tb_isa_run_monitor.sv
module tb_isa_run_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // DUT A: single hart, default parameters
   logic        rst_n_a, start_a;
   logic [0:0]  wen_a;
   logic [31:0] wdat_a;
   logic        cpu_rst_a, busy_a, done_a, pass_a, to_a;
   logic [0:0]  fh_a;
   logic [30:0] fc_a;
   logic [31:0] cnt_a;
   logic [0:0]  hd_a;

   isa_run_monitor #(.NUM_HARTS(1), .RESET_HOLD_CYCLES(30), .TIMEOUT_CYCLES(1000), .CNT_W(32)) dut_a (
      .clk(clk), .rst_n(rst_n_a), .start(start_a), .csr_wr_en(wen_a), .csr_wr_data(wdat_a),
      .cpu_rst(cpu_rst_a), .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(to_a),
      .fail_hart(fh_a), .fail_code(fc_a), .cycle_count(cnt_a), .hart_done(hd_a));

   // DUT B: four harts, short hold
   logic         rst_n_b, start_b;
   logic [3:0]   wen_b;
   logic [127:0] wdat_b;
   logic         cpu_rst_b, busy_b, done_b, pass_b, to_b;
   logic [1:0]   fh_b;
   logic [30:0]  fc_b;
   logic [31:0]  cnt_b;
   logic [3:0]   hd_b;

   isa_run_monitor #(.NUM_HARTS(4), .RESET_HOLD_CYCLES(4), .TIMEOUT_CYCLES(1000), .CNT_W(32)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .start(start_b), .csr_wr_en(wen_b), .csr_wr_data(wdat_b),
      .cpu_rst(cpu_rst_b), .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(to_b),
      .fail_hart(fh_b), .fail_code(fc_b), .cycle_count(cnt_b), .hart_done(hd_b));

   // DUT C: single hart, timeout disabled
   logic        rst_n_c, start_c;
   logic [0:0]  wen_c;
   logic [31:0] wdat_c;
   logic        cpu_rst_c, busy_c, done_c, pass_c, to_c;
   logic [0:0]  fh_c;
   logic [30:0] fc_c;
   logic [31:0] cnt_c;
   logic [0:0]  hd_c;

   isa_run_monitor #(.NUM_HARTS(1), .RESET_HOLD_CYCLES(3), .TIMEOUT_CYCLES(0), .CNT_W(32)) dut_c (
      .clk(clk), .rst_n(rst_n_c), .start(start_c), .csr_wr_en(wen_c), .csr_wr_data(wdat_c),
      .cpu_rst(cpu_rst_c), .busy(busy_c), .done(done_c), .pass(pass_c), .timeout(to_c),
      .fail_hart(fh_c), .fail_code(fc_c), .cycle_count(cnt_c), .hart_done(hd_c));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Pulse start on DUT A and return how many cycles the CPU reset was held.
   task automatic a_launch(output int n);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      n = 0;
      while (cpu_rst_a && busy_a && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic a_write(input logic [31:0] d);
      wen_a  = 1'b1;
      wdat_a = d;
      tick();
      wen_a  = 1'b0;
      wdat_a = '0;
   endtask

   int n;

   initial begin
      rst_n_a = 1'b0; start_a = 1'b0; wen_a = '0; wdat_a = '0;
      rst_n_b = 1'b0; start_b = 1'b0; wen_b = '0; wdat_b = '0;
      rst_n_c = 1'b0; start_c = 1'b0; wen_c = '0; wdat_c = '0;
      tick(); tick();

      // Reset values
      check("rst_cpu_rst", cpu_rst_a, 1);
      check("rst_busy",    busy_a,    0);
      check("rst_done",    done_a,    0);
      check("rst_pass",    pass_a,    0);
      check("rst_timeout", to_a,      0);
      check("rst_count",   cnt_a,     0);
      check("rst_hart_done", hd_a,    0);
      check("rst_fail_code", fc_a,    0);

      rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
      tick(); tick(); tick();
      check("idle_no_start_busy", busy_a, 0);

      // Run 1: pass at RUN cycle 40
      a_launch(n);
      check("p_hold_cycles", n, 30);
      repeat (40) tick();
      check("p_busy_before_write", busy_a, 1);
      a_write(32'h1);
      check("p_done",    done_a, 1);
      check("p_pass",    pass_a, 1);
      check("p_timeout", to_a,   0);
      check("p_count",   cnt_a,  41);
      check("p_cpu_rst", cpu_rst_a, 1);
      check("p_hart_done", hd_a, 1);
      start_a = 1'b0;
      repeat (5) tick();
      check("p_count_frozen", cnt_a,  41);
      check("p_done_held",    done_a, 1);

      // Run 2: write without done bit is ignored, then fail code 5
      a_launch(n);
      check("f_hold_cycles", n, 30);
      check("f_cleared_pass", pass_a, 0);
      check("f_cleared_hd",   hd_a,   0);
      repeat (5) tick();
      a_write(32'h4);
      check("f_bit0_ignored_hd",   hd_a,   0);
      check("f_bit0_ignored_busy", busy_a, 1);
      start_a = 1'b1;          // start mid-run must be ignored
      tick();
      start_a = 1'b0;
      a_write(32'hB);
      check("f_done",      done_a, 1);
      check("f_pass",      pass_a, 0);
      check("f_fail_code", fc_a,   5);
      check("f_fail_hart", fh_a,   0);
      check("f_timeout",   to_a,   0);
      check("f_count",     cnt_a,  8);
      a_write(32'h1);          // write in DONE is ignored
      check("f_done_write_code", fc_a,   5);
      check("f_done_write_pass", pass_a, 0);

      // Run 3: timeout
      a_launch(n);
      n = 0;
      while (!done_a && n < 2000) begin
         tick();
         n++;
      end
      check("t_run_cycles", n,     999);
      check("t_count",      cnt_a, 999);
      check("t_timeout",    to_a,  1);
      check("t_pass",       pass_a, 0);
      check("t_fail_code",  fc_a,  0);

      // Run 4: completion lands in the timeout cycle
      a_launch(n);
      repeat (998) tick();
      check("tl_busy", busy_a, 1);
      a_write(32'h1);
      check("tl_done",    done_a, 1);
      check("tl_pass",    pass_a, 1);
      check("tl_timeout", to_a,   0);
      check("tl_count",   cnt_a,  999);

      // Run 5: reset at RUN cycle 10, then a clean run
      a_launch(n);
      repeat (10) tick();
      rst_n_a = 1'b0;
      #1;
      check("ar_cpu_rst", cpu_rst_a, 1);
      check("ar_busy",    busy_a,    0);
      check("ar_done",    done_a,    0);
      check("ar_count",   cnt_a,     0);
      check("ar_pass",    pass_a,    0);
      tick();
      rst_n_a = 1'b1;
      repeat (3) tick();
      check("ar_stays_idle", busy_a, 0);
      a_launch(n);
      check("ar_hold_cycles", n, 30);
      repeat (2) tick();
      a_write(32'h1);
      check("ar_clean_count", cnt_a, 3);
      check("ar_clean_pass",  pass_a, 1);

      // DUT B: multi-hart priority and first-completion-wins
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      n = 0;
      while (cpu_rst_b && n < 100) begin
         tick();
         n++;
      end
      check("b_hold_cycles", n, 4);
      tick(); tick();
      wen_b  = 4'b1010;
      wdat_b = {32'h7, 32'h0, 32'h3, 32'h0};
      tick();
      check("b_hd_31",    hd_b,   4'b1010);
      check("b_busy_31",  busy_b, 1);
      check("b_fh_31",    fh_b,   1);
      check("b_fc_31",    fc_b,   1);
      wen_b  = 4'b1000;
      wdat_b = {32'h1, 32'h0, 32'h0, 32'h0};
      tick();
      wen_b  = 4'b0101;
      wdat_b = {32'h0, 32'h1, 32'h0, 32'h1};
      tick();
      wen_b  = '0;
      wdat_b = '0;
      check("b_done",  done_b, 1);
      check("b_pass",  pass_b, 0);
      check("b_hd",    hd_b,   4'hF);
      check("b_fh",    fh_b,   1);
      check("b_fc",    fc_b,   1);

      // Second run: only hart 3 fails; its later good write must not overwrite
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      check("b2_cleared_hd", hd_b, 0);
      n = 0;
      while (cpu_rst_b && n < 100) begin
         tick();
         n++;
      end
      wen_b  = 4'b1000;
      wdat_b = {32'h7, 32'h0, 32'h0, 32'h0};
      tick();
      wen_b  = 4'b1000;
      wdat_b = {32'h1, 32'h0, 32'h0, 32'h0};
      tick();
      wen_b  = 4'b0111;
      wdat_b = {32'h0, 32'h1, 32'h1, 32'h1};
      tick();
      wen_b  = '0;
      wdat_b = '0;
      check("b2_done", done_b, 1);
      check("b2_pass", pass_b, 0);
      check("b2_fh",   fh_b,   3);
      check("b2_fc",   fc_b,   3);
      check("b2_count", cnt_b, 3);

      // DUT C: timeout disabled
      start_c = 1'b1;
      tick();
      start_c = 1'b0;
      n = 0;
      while (cpu_rst_c && n < 100) begin
         tick();
         n++;
      end
      check("c_hold_cycles", n, 3);
      repeat (5000) tick();
      check("c_busy",    busy_c, 1);
      check("c_done",    done_c, 0);
      check("c_count",   cnt_c,  5000);
      check("c_timeout", to_c,   0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
